iz_param_loader: RTL and testbench

IZ_PARAM_LOADER -- requirements
Module: iz_param_loader

---
 rtl/iz_pkg.sv | 28 ++
 rtl/iz_loader_watchdog.sv | 28 ++
 rtl/iz_param_loader.sv | 142 ++++++++++++++
 tb/tb_iz_param_loader.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iz_pkg.sv
// Shared types and constants for the Izhikevich neuron parameter loader.
package iz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2,
    ST_COMMIT  = 2'd3
  } iz_state_e;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
  localparam int         PAYLOAD_LEN    = 8;
  localparam int         SCALE          = 64;

  // Reset-default neuron (regular spiking): a=0.02, b=0.2, c=-65, d=8 at scale 64
  localparam logic [15:0] DEFAULT_A = 16'h0001;
  localparam logic [15:0] DEFAULT_B = 16'h000D;
  localparam logic [15:0] DEFAULT_C = 16'(-65 * SCALE);
  localparam logic [15:0] DEFAULT_D = 16'(8 * SCALE);

  function automatic logic [7:0] payload_xor(input logic [8*PAYLOAD_LEN-1:0] p);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < PAYLOAD_LEN; i++) x ^= p[8*i +: 8];
    return x;
  endfunction

endpackage

// File: rtl/iz_loader_watchdog.sv
// Mid-frame idle counter; expired fires on the idle edge that reaches TIMEOUT_CYCLES.
module iz_loader_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  // A zero timeout never expires; the counter then free-runs harmlessly.
  assign expired = (TIMEOUT_CYCLES != 0) && run && !clear && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (run) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/iz_param_loader.sv
// Loads a framed serial byte stream into the four neuron parameters.
// Build option: IZ_LOADER_CHECKSUM_EN appends an XOR checksum byte and the CHECK state.
module iz_param_loader
  import iz_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] HEADER_BYTE    = DEFAULT_HEADER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  load_byte,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [15:0] param_a,
  output logic [15:0] param_b,
  output logic [15:0] param_c,
  output logic [15:0] param_d,
  output logic        params_ready,
  output logic        load_done,
  output logic        load_error,
  output iz_state_e   dbg_state
);

  localparam int PW = 8 * PAYLOAD_LEN;
  localparam logic [PW-1:0] DEFAULT_PARAMS = {DEFAULT_D, DEFAULT_C, DEFAULT_B, DEFAULT_A};
  localparam logic [2:0] LAST_IDX = 3'(PAYLOAD_LEN - 1);

  iz_state_e     state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [PW-1:0] shadow_q, shadow_d;
  logic [PW-1:0] params_q, params_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          abort;
  logic          accept, wd_run, wd_clear, wd_expired;

  // Handshake: a byte transfers on a rising edge where load_valid && load_ready;
  // load_ready depends only on state, so a producer may hold valid across COMMIT.
  assign load_ready = (state_q != ST_COMMIT);
  assign accept     = load_valid && load_ready;
  assign wd_run     = (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
  assign wd_clear   = accept || !wd_run;

  iz_loader_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .run     (wd_run),
    .expired (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    params_d = params_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    abort    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && load_byte == HEADER_BYTE) begin
          state_d = ST_PAYLOAD;
          idx_d   = '0;
          ready_d = 1'b0;
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          shadow_d[{idx_q, 3'b000} +: 8] = load_byte;
          idx_d = idx_q + 3'd1;
          if (idx_q == LAST_IDX) begin
`ifdef IZ_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_COMMIT;
`endif
          end
        end else if (wd_expired) begin
          abort = 1'b1;
        end
      end
`ifdef IZ_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          if (load_byte == payload_xor(shadow_q)) state_d = ST_COMMIT;
          else abort = 1'b1;
        end else if (wd_expired) begin
          abort = 1'b1;
        end
      end
`endif
      ST_COMMIT: begin
        params_d = shadow_q;
        ready_d  = 1'b1;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Committed parameters are untouched by an abort; only the frame is dropped.
    if (abort) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      shadow_d = '0;
      ready_d  = 1'b1;
      error_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      params_q <= DEFAULT_PARAMS;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      params_q <= params_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign param_a      = params_q[15:0];
  assign param_b      = params_q[31:16];
  assign param_c      = params_q[47:32];
  assign param_d      = params_q[63:48];
  assign params_ready = ready_q;
  assign load_done    = done_q;
  assign load_error   = error_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_iz_param_loader.sv
// Self-checking bench for iz_param_loader against a frame-level reference model.
module tb_iz_param_loader;
  import iz_pkg::*;

  localparam int TO = 4;
`ifdef IZ_LOADER_CHECKSUM_EN
  localparam int FRAME_LEN = 9;
  localparam bit CK = 1'b1;
`else
  localparam int FRAME_LEN = 8;
  localparam bit CK = 1'b0;
`endif
  localparam logic [63:0] DEF_PARAMS = 64'h0200_EFC0_000D_0001;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  load_byte = 8'h00;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] param_a, param_b, param_c, param_d;
  logic        params_ready, load_done, load_error;
  iz_state_e   dbg_state;

  always #5 clk = ~clk;

  iz_param_loader #(.TIMEOUT_CYCLES(TO), .HEADER_BYTE(8'hA5)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_byte    (load_byte),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .param_a      (param_a),
    .param_b      (param_b),
    .param_c      (param_c),
    .param_d      (param_d),
    .params_ready (params_ready),
    .load_done    (load_done),
    .load_error   (load_error),
    .dbg_state    (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: parameter sets awaiting their commit edge
  logic [63:0] exp_q[$];
  logic [63:0] exp_params;
  bit          exp_ready, exp_done, exp_err, exp_lready;
  bit          m_in_frame;
  logic [7:0]  m_bytes[$];
  int          m_idle;
  bit          last_acc;

  logic [67:0] dut_vec, exp_vec;
  logic [63:0] dut_params;
  assign dut_params = {param_d, param_c, param_b, param_a};
  assign dut_vec = {dut_params, params_ready, load_done, load_error, load_ready};
  assign exp_vec = {exp_params, exp_ready, exp_done, exp_err, exp_lready};

  task automatic model_reset();
    exp_params = DEF_PARAMS;
    exp_ready  = 1'b1;
    exp_done   = 1'b0;
    exp_err    = 1'b0;
    exp_lready = 1'b1;
    m_in_frame = 1'b0;
    m_idle     = 0;
    m_bytes.delete();
    exp_q.delete();
  endtask

  task automatic model_edge(input bit acc, input logic [7:0] b);
    logic [7:0] x;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (exp_q.size() != 0) begin
      exp_params = exp_q.pop_front();
      exp_ready  = 1'b1;
      exp_done   = 1'b1;
    end else if (!m_in_frame) begin
      if (acc && b == 8'hA5) begin
        m_in_frame = 1'b1;
        m_bytes.delete();
        m_idle    = 0;
        exp_ready = 1'b0;
      end
    end else if (acc) begin
      m_bytes.push_back(b);
      m_idle = 0;
      if (m_bytes.size() == FRAME_LEN) begin
        m_in_frame = 1'b0;
        x = 8'h00;
        for (int i = 0; i < 8; i++) x ^= m_bytes[i];
        if (!CK || x == m_bytes[FRAME_LEN-1]) begin
          exp_q.push_back({m_bytes[7], m_bytes[6], m_bytes[5], m_bytes[4],
                           m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
        end else begin
          exp_err   = 1'b1;
          exp_ready = 1'b1;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_in_frame = 1'b0;
        exp_err    = 1'b1;
        exp_ready  = 1'b1;
      end
    end
    exp_lready = (exp_q.size() == 0);
  endtask

  // Drive one clock cycle from a negedge; returns at the next negedge.
  task automatic cycle(input bit v, input logic [7:0] b);
    load_valid = v;
    load_byte  = b;
    last_acc   = v && exp_lready;
    @(posedge clk);
    model_edge(last_acc, b);
    @(negedge clk);
  endtask

  task automatic do_reset();
    load_valid = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic mk_frame(input logic [63:0] p, input bit bad, output bq_t f);
    logic [7:0] x;
    f.delete();
    f.push_back(8'hA5);
    x = 8'h00;
    for (int i = 0; i < 8; i++) begin
      f.push_back(p[8*i +: 8]);
      x ^= p[8*i +: 8];
    end
    if (CK) f.push_back(bad ? (x ^ 8'h01) : x);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", dut_vec, exp_vec);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_known_frame();
    bq_t f;
    f = '{8'hA5, 8'h02, 8'h00, 8'h0D, 8'h00, 8'hC0, 8'hEF, 8'h00, 8'h02};
    if (CK) f.push_back(8'h22);
    for (int i = 0; i < f.size(); i++) begin
      cycle(1'b1, f[i]);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL known_frame_byte%0d got %h exp %h", i, dut_vec, exp_vec);
      end
    end
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0 || params_ready !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL known_frame_commit_cycle got rdy=%b pr=%b done=%b exp 0 0 0",
               load_ready, params_ready, load_done);
    end
    cycle(1'b0, 8'h00);
    checks++;
    if (dut_params !== 64'h0200_EFC0_000D_0002 || params_ready !== 1'b1 || load_done !== 1'b1) begin
      errors++;
      $display("FAIL known_frame_commit got %h pr=%b done=%b exp 0200efc0000d0002 1 1",
               dut_params, params_ready, load_done);
    end
    cycle(1'b0, 8'h00);
    checks++;
    if (load_done !== 1'b0 || dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL known_frame_done_pulse got %h exp %h", dut_vec, exp_vec);
    end
  endtask

`ifdef IZ_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    bq_t f;
    do_reset();
    f = '{8'hA5, 8'h02, 8'h00, 8'h0D, 8'h00, 8'hC0, 8'hEF, 8'h00, 8'h02, 8'h23};
    for (int i = 0; i < f.size(); i++) cycle(1'b1, f[i]);
    load_valid = 1'b0;
    checks++;
    if (load_error !== 1'b1 || load_done !== 1'b0 || params_ready !== 1'b1 || dut_params !== DEF_PARAMS) begin
      errors++;
      $display("FAIL bad_checksum got err=%b done=%b pr=%b par=%h exp 1 0 1 %h",
               load_error, load_done, params_ready, dut_params, DEF_PARAMS);
    end
    cycle(1'b0, 8'h00);
    checks++;
    if (load_error !== 1'b0 || dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL bad_checksum_pulse got %h exp %h", dut_vec, exp_vec);
    end
  endtask
`endif

  task automatic test_junk_prefix();
    bq_t f;
    logic [63:0] p;
    p = {$urandom, $urandom};
    mk_frame(p, 1'b0, f);
    cycle(1'b1, 8'h5A);
    cycle(1'b1, 8'h11);
    checks++;
    if (params_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL junk_ignored got pr=%b state=%0d exp 1 0", params_ready, dbg_state);
    end
    for (int i = 0; i < f.size(); i++) cycle(1'b1, f[i]);
    cycle(1'b0, 8'h00);
    checks++;
    if (dut_params !== p || load_done !== 1'b1 || dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL junk_then_frame got %h exp %h params %h", dut_vec, exp_vec, p);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h02);
    for (int k = 1; k <= TO; k++) begin
      cycle(1'b0, 8'h00);
      checks++;
      if (load_error !== (k == TO) || dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL timeout_idle%0d got err=%b vec=%h exp err=%b vec=%h",
                 k, load_error, dut_vec, (k == TO), exp_vec);
      end
    end
    checks++;
    if (dbg_state !== ST_IDLE || dut_params !== DEF_PARAMS || params_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort got state=%0d par=%h pr=%b exp 0 %h 1",
               dbg_state, dut_params, params_ready, DEF_PARAMS);
    end
    cycle(1'b0, 8'h00);
    checks++;
    if (load_error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse got %b exp 0", load_error);
    end
  endtask

  task automatic test_reset_midframe();
    bq_t f;
    logic [63:0] p;
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom));
    load_valid = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (load_error !== 1'b0 || params_ready !== 1'b1 || dut_params !== DEF_PARAMS || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_midframe got err=%b pr=%b par=%h state=%0d exp 0 1 %h 0",
               load_error, params_ready, dut_params, dbg_state, DEF_PARAMS);
    end
    reset = 1'b0;
    model_reset();
    p = {$urandom, $urandom};
    mk_frame(p, 1'b0, f);
    for (int i = 0; i < f.size(); i++) begin
      cycle(1'b1, f[i]);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_midframe_refill%0d got %h exp %h", i, dut_vec, exp_vec);
      end
    end
    cycle(1'b0, 8'h00);
    checks++;
    if (dut_params !== p || load_done !== 1'b1) begin
      errors++;
      $display("FAIL reset_midframe_commit got %h done=%b exp %h 1", dut_params, load_done, p);
    end
  endtask

  task automatic test_back_to_back();
    bq_t f, sq;
    logic [63:0] p1, p2;
    int not_ready, n;
    p1 = {$urandom, $urandom};
    p2 = {$urandom, $urandom};
    mk_frame(p1, 1'b0, f);
    foreach (f[i]) sq.push_back(f[i]);
    mk_frame(p2, 1'b0, f);
    foreach (f[i]) sq.push_back(f[i]);
    not_ready = 0;
    n = 0;
    while (n < 40 && (sq.size() != 0 || exp_q.size() != 0)) begin
      if (load_ready !== 1'b1) not_ready++;
      if (sq.size() != 0) cycle(1'b1, sq[0]);
      else cycle(1'b0, 8'h00);
      if (last_acc) void'(sq.pop_front());
      n++;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL back_to_back_cycle%0d got %h exp %h", n, dut_vec, exp_vec);
      end
    end
    checks++;
    if (not_ready != 2 || dut_params !== p2 || sq.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_summary got stalls=%0d par=%h left=%0d exp 2 %h 0",
               not_ready, dut_params, sq.size(), p2);
    end
  endtask

  task automatic test_random();
    bq_t f, sq;
    int gq[$];
    int gap, n, r;
    for (int fr = 0; fr < 10; fr++) begin
      for (int j = 0; j < $urandom_range(0, 2); j++) begin
        sq.push_back(8'($urandom_range(0, 255)));
        gq.push_back(0);
      end
      mk_frame({$urandom, $urandom}, CK && ($urandom_range(0, 3) == 0), f);
      foreach (f[i]) begin
        sq.push_back(f[i]);
        r = $urandom_range(0, 29);
        gq.push_back(r < 22 ? 0 : (r < 29 ? $urandom_range(1, TO - 1) : TO + 1));
      end
    end
    gap = gq[0];
    n = 0;
    while (sq.size() != 0 && n < 1000) begin
      if (gap > 0) begin
        cycle(1'b0, 8'($urandom));
        gap--;
      end else begin
        cycle(1'b1, sq[0]);
        if (last_acc) begin
          void'(sq.pop_front());
          void'(gq.pop_front());
          if (gq.size() != 0) gap = gq[0];
        end
      end
      n++;
      checks++;
      if (dut_vec !== exp_vec || (load_done && load_error)) begin
        errors++;
        $display("FAIL random_cycle%0d got %h exp %h", n, dut_vec, exp_vec);
      end
    end
    for (int k = 0; k < TO + 2; k++) begin
      cycle(1'b0, 8'h00);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL random_drain%0d got %h exp %h", k, dut_vec, exp_vec);
      end
    end
    checks++;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL random_budget got %0d bytes left exp 0", sq.size());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_known_frame();
`ifdef IZ_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_junk_prefix();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1);
  end

endmodule
